fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage.
- Owns the program counter and drives the byte-addressed instruction memory read port, which has combinational read and little-endian word assembly.
- Registers the returned word into the IF/ID pipeline register that feeds decode.
- Handles stall requests from the hazard unit and redirects (taken branch/jump) from execute.

Parameters:
- ADDRWIDTH, 32, PC / memory address width.
- DATAWIDTH, 32, instruction word width.
- RESET_PC, 32'h01000000, PC value loaded on reset (program load base).
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID this cycle
- redirect_valid  input  1  execute: load new PC this cycle
- redirect_target  input  ADDRWIDTH  new PC target
- imem_address  output  ADDRWIDTH  instruction memory byte address (= pc)
- imem_read_write  output  1  instruction memory direction; constant 0 (read)
- imem_data_in  input  DATAWIDTH  instruction word returned combinationally by memory
- if_id_valid  output  1  IF/ID holds a real instruction
- if_id_pc  output  ADDRWIDTH  PC of the instruction held in IF/ID
- if_id_pc_plus4  output  ADDRWIDTH  if_id_pc + 4
- if_id_instr  output  DATAWIDTH  instruction word held in IF/ID
- misalign_err  output  1  sticky flag: a redirect target was not word-aligned
- fetch_count  output  32  performance counter (see Optional Feature)
- stall_count  output  32  performance counter (see Optional Feature)

Behaviour:
- Clocking and reset:
  - Clock is the single port `clock`; reset is `reset`, synchronous and active-high.
  - All state updates occur on the rising edge of `clock`.
- Reset values:
  - pc = RESET_PC
  - if_id_valid = 0, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_instr = NOP_INSTR
  - misalign_err = 0, counters = 0
- Memory interface:
  - imem_address = pc, combinationally.
  - imem_read_write tied to 0.
  - imem_data_in is sampled at the same edge that advances pc; fetch latency is 0 cycles to the memory and 1 cycle to IF/ID.
- Priority per edge, with reset highest: reset > redirect_valid > stall > normal advance.
- Normal advance (no redirect, no stall):
  - if_id_pc <= pc
  - if_id_pc_plus4 <= pc+4
  - if_id_instr <= imem_data_in
  - if_id_valid <= 1
  - pc <= pc+4
- Stall (no redirect): pc and all if_id_* hold their values. The word at imem_address is re-read next cycle.
- Redirect:
  - pc <= {redirect_target[ADDRWIDTH-1:2], 2'b00}.
  - IF/ID is flushed: if_id_valid <= 0, if_id_instr <= NOP_INSTR, if_id_pc/if_id_pc_plus4 hold.
  - The word fetched at the old pc is discarded.
  - Redirect wins over a simultaneous stall: PC is loaded and IF/ID is flushed regardless of stall.
- Misaligned target: if redirect_valid and redirect_target[1:0] != 0, misalign_err <= 1 (sticky until reset). The aligned target is still loaded.
- Wrap-around: pc+4 is computed modulo 2^ADDRWIDTH; 32'hFFFFFFFC advances to 32'h00000000 without any flag.
- Reset mid-stall or mid-redirect: reset takes effect at that edge; the next cycle fetches from RESET_PC with IF/ID invalid.
- Consecutive redirects: each one reloads pc; only the last takes effect; IF/ID stays invalid throughout.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments on each edge where IF/ID is loaded with a valid instruction (normal advance).
  - stall_count increments on each edge where stall=1 and redirect_valid=0.
  - Both counters are 32-bit, wrap silently, and are cleared by reset.
- Undefined: counter registers are not instantiated; fetch_count and stall_count are tied to 0.

Test Plan:
- Reset then 3 free-running cycles, memory words 0x00500093/0x00A00113/0x002081B3 at 0x01000000/04/08 -> if_id_pc 0x01000000, 0x01000004, 0x01000008 on successive cycles with matching words, if_id_valid=1; first cycle after reset if_id_valid=0, if_id_instr=0x00000013.
- stall=1 for 2 cycles at pc=0x01000008 -> pc and if_id_* unchanged for both cycles; with FETCH_PERF_CNT_EN, stall_count=2.
- redirect_valid=1, target 0x01000040 -> next cycle imem_address=0x01000040, if_id_valid=0, if_id_instr=0x00000013; the following cycle if_id_pc=0x01000040.
- redirect_valid=1 and stall=1 together, target 0x01000020 -> pc=0x01000020, IF/ID flushed (redirect wins).
- redirect target 0x01000042 -> pc=0x01000040, misalign_err=1 and it stays 1 until reset.
- Force pc=0xFFFFFFFC via redirect, then advance -> pc=0x00000000, if_id_pc=0xFFFFFFFC, if_id_pc_plus4=0x00000000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, drives the imem read port, loads IF/ID.
// Latency: memory read is combinational; a fetched word reaches IF/ID one edge after pc presents it.
// Backpressure: stall holds pc and IF/ID; a redirect wins over a stall and flushes IF/ID.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN; otherwise they read as zero.
module fetch_stage #(
    parameter int unsigned          ADDRWIDTH = 32,
    parameter int unsigned          DATAWIDTH = 32,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = 32'h01000000,
    parameter logic [DATAWIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADDRWIDTH-1:0] redirect_target,
    output logic [ADDRWIDTH-1:0] imem_address,
    output logic                 imem_read_write,
    input  logic [DATAWIDTH-1:0] imem_data_in,
    output logic                 if_id_valid,
    output logic [ADDRWIDTH-1:0] if_id_pc,
    output logic [ADDRWIDTH-1:0] if_id_pc_plus4,
    output logic [DATAWIDTH-1:0] if_id_instr,
    output logic                 misalign_err,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count
);

    // Per-edge action, already prioritised: redirect > stall > advance.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_act_e;

    fetch_act_e             act;

    logic [ADDRWIDTH-1:0]   pc_q, pc_d;
    logic [ADDRWIDTH-1:0]   pc_plus4;
    logic [ADDRWIDTH-1:0]   redirect_aligned;
    logic                   redirect_misaligned;

    logic                   if_id_valid_q, if_id_valid_d;
    logic [ADDRWIDTH-1:0]   if_id_pc_q, if_id_pc_d;
    logic [ADDRWIDTH-1:0]   if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [DATAWIDTH-1:0]   if_id_instr_q, if_id_instr_d;
    logic                   misalign_err_q, misalign_err_d;

    // Sequential PC increment wraps naturally modulo 2^ADDRWIDTH.
    assign pc_plus4            = pc_q + ADDRWIDTH'(4);
    // Low two target bits are dropped; they only feed the sticky misalign flag.
    assign redirect_aligned    = {redirect_target[ADDRWIDTH-1:2], 2'b00};
    assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

    // Memory port is a pure read port addressed directly by the PC.
    assign imem_address    = pc_q;
    assign imem_read_write = 1'b0;

    // Decode the control inputs into a single prioritised action.
    always_comb begin
        act = ACT_ADVANCE;
        if (redirect_valid) begin
            act = ACT_REDIRECT;
        end else if (stall) begin
            act = ACT_STALL;
        end
    end

    // Next-state for PC and the IF/ID register.
    always_comb begin
        pc_d             = pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        unique case (act)
            ACT_REDIRECT: begin
                // Word at the old pc is discarded; IF/ID pc fields keep their last value.
                pc_d          = redirect_aligned;
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
            ACT_STALL: begin
                // Everything holds; the same address is re-read next cycle.
            end
            ACT_ADVANCE: begin
                pc_d             = pc_plus4;
                if_id_valid_d    = 1'b1;
                if_id_pc_d       = pc_q;
                if_id_pc_plus4_d = pc_plus4;
                if_id_instr_d    = imem_data_in;
            end
            default: begin
            end
        endcase
    end

    // Sticky misalignment flag, only cleared by reset.
    always_comb begin
        misalign_err_d = misalign_err_q;
        if (redirect_valid && redirect_misaligned) begin
            misalign_err_d = 1'b1;
        end
    end

    // PC, IF/ID and error-flag registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_instr_q    <= NOP_INSTR;
            misalign_err_q   <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            misalign_err_q   <= misalign_err_d;
        end
    end

    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;
    assign misalign_err   = misalign_err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Count valid loads into IF/ID and stall cycles not overridden by a redirect.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (act == ACT_ADVANCE) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (act == ACT_STALL) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Counter registers; they wrap silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus reset-in-flight sequences.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] RST_PC = 32'h01000000;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_read_write (imem_read_write),
        .imem_data_in    (imem_data_in),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_instr     (if_id_instr),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
    );

    always #5 clock = ~clock;

    // Instruction memory: three program words, elsewhere {addr[15:0], 16'hBEEF}.
    always_comb begin
        case (imem_address)
            32'h01000000: imem_data_in = 32'h00500093;
            32'h01000004: imem_data_in = 32'h00A00113;
            32'h01000008: imem_data_in = 32'h002081B3;
            default:      imem_data_in = {imem_address[15:0], 16'hBEEF};
        endcase
    end

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        vld;
        logic [31:0] ifpc;
        logic [31:0] plus4;
        logic [31:0] instr;
        logic        mis;
        logic [31:0] fc;
        logic [31:0] sc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic s, logic r, logic [31:0] t, logic [31:0] p, logic v,
                                logic [31:0] ip, logic [31:0] p4, logic [31:0] in, logic m,
                                logic [31:0] fc, logic [31:0] sc);
        vec_t x;
        x.stall = s; x.rv = r; x.tgt = t; x.pc = p; x.vld = v; x.ifpc = ip;
        x.plus4 = p4; x.instr = in; x.mis = m; x.fc = fc; x.sc = sc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] p, input logic v,
                             input logic [31:0] ip, input logic [31:0] p4,
                             input logic [31:0] in, input logic m,
                             input logic [31:0] fc, input logic [31:0] sc);
        check({tag, "_pc"},    imem_address, p);
        check({tag, "_rw"},    {31'd0, imem_read_write}, 32'd0);
        check({tag, "_vld"},   {31'd0, if_id_valid}, {31'd0, v});
        check({tag, "_ifpc"},  if_id_pc, ip);
        check({tag, "_plus4"}, if_id_pc_plus4, p4);
        check({tag, "_instr"}, if_id_instr, in);
        check({tag, "_mis"},   {31'd0, misalign_err}, {31'd0, m});
        check({tag, "_fcnt"},  fetch_count, PERF ? fc : 32'd0);
        check({tag, "_scnt"},  stall_count, PERF ? sc : 32'd0);
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] t);
        @(negedge clock);
        reset = r; stall = s; redirect_valid = rv; redirect_target = t;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //                stall rv  target         pc            vld ifpc          plus4         instr         mis fc     sc
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        32'h01000004, 1, 32'h01000000, 32'h01000004, 32'h00500093, 0, 32'd1, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        32'h01000008, 1, 32'h01000004, 32'h01000008, 32'h00A00113, 0, 32'd2, 32'd0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,        32'h01000008, 1, 32'h01000004, 32'h01000008, 32'h00A00113, 0, 32'd2, 32'd1);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,        32'h01000008, 1, 32'h01000004, 32'h01000008, 32'h00A00113, 0, 32'd2, 32'd2);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,        32'h0100000C, 1, 32'h01000008, 32'h0100000C, 32'h002081B3, 0, 32'd3, 32'd2);
        vecs[5]  = mk(1'b0, 1'b1, 32'h01000040, 32'h01000040, 0, 32'h01000008, 32'h0100000C, NOP,          0, 32'd3, 32'd2);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,        32'h01000044, 1, 32'h01000040, 32'h01000044, 32'h0040BEEF, 0, 32'd4, 32'd2);
        vecs[7]  = mk(1'b1, 1'b1, 32'h01000020, 32'h01000020, 0, 32'h01000040, 32'h01000044, NOP,          0, 32'd4, 32'd2);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,        32'h01000020, 0, 32'h01000040, 32'h01000044, NOP,          0, 32'd4, 32'd3);
        vecs[9]  = mk(1'b0, 1'b1, 32'h01000042, 32'h01000040, 0, 32'h01000040, 32'h01000044, NOP,          1, 32'd4, 32'd3);
        vecs[10] = mk(1'b0, 1'b1, 32'h01000010, 32'h01000010, 0, 32'h01000040, 32'h01000044, NOP,          1, 32'd4, 32'd3);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,        32'h01000014, 1, 32'h01000010, 32'h01000014, 32'h0010BEEF, 1, 32'd5, 32'd3);
        vecs[12] = mk(1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h01000010, 32'h01000014, NOP,          1, 32'd5, 32'd3);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,        32'h00000000, 1, 32'hFFFFFFFC, 32'h00000000, 32'hFFFCBEEF, 1, 32'd6, 32'd3);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,        32'h00000004, 1, 32'h00000000, 32'h00000004, 32'h0000BEEF, 1, 32'd7, 32'd3);

        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_all("reset", RST_PC, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].vld, vecs[i].ifpc,
                      vecs[i].plus4, vecs[i].instr, vecs[i].mis, vecs[i].fc, vecs[i].sc);
        end

        // Reset arriving together with stall and a misaligned redirect clears everything.
        step(1'b1, 1'b1, 1'b1, 32'h01000042);
        check_all("rst_redir", RST_PC, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_all("post_rst", 32'h01000004, 1'b1, 32'h01000000, 32'h01000004, 32'h00500093,
                  1'b0, 32'd1, 32'd0);

        // Reset during a stall restarts from RESET_PC with IF/ID invalid.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_all("stall1", 32'h01000004, 1'b1, 32'h01000000, 32'h01000004, 32'h00500093,
                  1'b0, 32'd1, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_all("rst_stall", RST_PC, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_all("restart", 32'h01000004, 1'b1, 32'h01000000, 32'h01000004, 32'h00500093,
                  1'b0, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
